// File: rtl/vector_unit_stream_if.sv
// rtl/vector_unit_stream_if.sv - command/response bundle for the queued vector unit
interface vector_unit_stream_if #(
  parameter int els_p  = 8,
  parameter int vlen_p = 16,
  parameter int vdw_p  = 8
);
  localparam int v_addr_w = $clog2(els_p);
  localparam int vl_w     = $clog2(vlen_p + 1);
  localparam int data_w   = vlen_p * vdw_p;

  logic                v_i;
  logic                ready_o;
  logic [3:0]          op_i;
  logic [v_addr_w-1:0] addrA_i;
  logic [v_addr_w-1:0] addrB_i;
  logic [v_addr_w-1:0] addrC_i;
  logic [vdw_p-1:0]    scalar_i;
  logic [vl_w-1:0]     vl_i;
  logic [data_w-1:0]   w_data_i;
  logic                v_o;
  logic [data_w-1:0]   r_data_o;
  logic                err_o;
  logic                yumi_i;

  modport slave (
    input  v_i, op_i, addrA_i, addrB_i, addrC_i, scalar_i, vl_i, w_data_i, yumi_i,
    output ready_o, v_o, r_data_o, err_o
  );

  modport master (
    output v_i, op_i, addrA_i, addrB_i, addrC_i, scalar_i, vl_i, w_data_i, yumi_i,
    input  ready_o, v_o, r_data_o, err_o
  );
endinterface

// File: rtl/vector_unit_stream.sv
// rtl/vector_unit_stream.sv - queued, runtime-length vector unit with its own VRF
// Commands queue in a small FIFO; one command executes lanes_p elements per beat.

module vector_unit_stream_fifo #(
  parameter int width_p = 8,
  parameter int depth_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cnt_w = $clog2(depth_p + 1);

  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic [cnt_w-1:0]   count;

  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == cnt_w'(depth_p));
  assign empty_o = (count == '0);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= bump(wr_ptr);
      if (pop_i)  rd_ptr <= bump(rd_ptr);
      if (push_i && !pop_i)      count <= count + 1'b1;
      else if (!push_i && pop_i) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end
endmodule

module vector_unit_stream #(
  parameter int els_p       = 8,
  parameter int vlen_p      = 16,
  parameter int vdw_p       = 8,
  parameter int lanes_p     = 4,
  parameter int cmd_depth_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  vector_unit_stream_if.slave  bus
);
  localparam int v_addr_w = $clog2(els_p);
  localparam int vl_w     = $clog2(vlen_p + 1);
  localparam int data_w   = vlen_p * vdw_p;
  localparam int idx_w    = $clog2(vlen_p);

  localparam logic [3:0] op_redsum = 4'b0011;
  localparam logic [3:0] op_read   = 4'b1000;
  localparam logic [3:0] op_write  = 4'b1001;

  typedef struct packed {
    logic [3:0]          op;
    logic [v_addr_w-1:0] a;
    logic [v_addr_w-1:0] b;
    logic [v_addr_w-1:0] c;
    logic [vdw_p-1:0]    scalar;
    logic [vl_w-1:0]     vl;
    logic [data_w-1:0]   wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state;
  cmd_t              cmd_in;
  cmd_t              head;
  cmd_t              cur;
  logic              live;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [vl_w-1:0]   base;
  logic [vdw_p-1:0]  acc;
  logic              v_r;
  logic              err_r;
  logic [vdw_p-1:0]  vrf  [els_p][vlen_p];
  logic [vdw_p-1:0]  resp [vlen_p];
  logic [data_w-1:0] r_data;

  logic [vl_w:0]     lane_idx [lanes_p];
  logic              lane_act [lanes_p];
  logic [vdw_p-1:0]  lane_a   [lanes_p];
  logic [vdw_p-1:0]  lane_b   [lanes_p];
  logic [vdw_p-1:0]  lane_res [lanes_p];
  logic [vdw_p-1:0]  beat_sum;
  logic [vl_w:0]     next_base;
  logic              last_beat;
  logic              is_arith;
  logic              do_write;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1001: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  // ready_o stays low while in reset and rises on the first edge afterwards
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) live <= 1'b0;
    else            live <= 1'b1;
  end

  assign bus.ready_o = live & ~fifo_full;
  assign push        = bus.v_i & bus.ready_o;
  assign pop         = (state == S_IDLE) & ~fifo_empty;

  always_comb begin
    cmd_in        = '0;
    cmd_in.op     = bus.op_i;
    cmd_in.a      = bus.addrA_i;
    cmd_in.b      = bus.addrB_i;
    cmd_in.c      = bus.addrC_i;
    cmd_in.scalar = bus.scalar_i;
    cmd_in.vl     = (bus.vl_i > vl_w'(vlen_p)) ? vl_w'(vlen_p) : bus.vl_i;
    cmd_in.wdata  = bus.w_data_i;
  end

  vector_unit_stream_fifo #(
    .width_p ($bits(cmd_t)),
    .depth_p (cmd_depth_p)
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (cmd_in),
    .pop_i     (pop),
    .data_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    is_arith  = cur.op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110};
    do_write  = (state == S_EXEC) && (is_arith || cur.op == op_write);
    next_base = {1'b0, base} + (vl_w + 1)'(lanes_p);
    last_beat = (next_base >= {1'b0, cur.vl});
    beat_sum  = acc;
    for (int l = 0; l < lanes_p; l++) begin
      lane_idx[l] = {1'b0, base} + (vl_w + 1)'(l);
      lane_act[l] = (lane_idx[l] < {1'b0, cur.vl});
      lane_a[l]   = vrf[cur.a][lane_idx[l][idx_w-1:0]];
      lane_b[l]   = cur.op[2] ? cur.scalar : vrf[cur.b][lane_idx[l][idx_w-1:0]];
      if (cur.op == op_write)
        lane_res[l] = cur.wdata[lane_idx[l][idx_w-1:0] * vdw_p +: vdw_p];
      else if (cur.op == op_read)
        lane_res[l] = lane_a[l];
      else begin
        case (cur.op[1:0])
          2'b00:   lane_res[l] = lane_a[l] + lane_b[l];
          2'b01:   lane_res[l] = lane_a[l] - lane_b[l];
          default: lane_res[l] = lane_a[l] * lane_b[l];
        endcase
      end
      if (lane_act[l]) beat_sum = beat_sum + lane_a[l];
    end
  end

  // Reads above see the pre-edge VRF, so C aliasing A or B is safe
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++)
        for (int j = 0; j < vlen_p; j++)
          vrf[i][j] <= '0;
    end else if (do_write) begin
      for (int l = 0; l < lanes_p; l++)
        if (lane_act[l]) vrf[cur.c][lane_idx[l][idx_w-1:0]] <= lane_res[l];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= S_IDLE;
      cur   <= '0;
      base  <= '0;
      acc   <= '0;
      v_r   <= 1'b0;
      err_r <= 1'b0;
      for (int j = 0; j < vlen_p; j++) resp[j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur  <= head;
            base <= '0;
            acc  <= '0;
            for (int j = 0; j < vlen_p; j++) resp[j] <= '0;
            if (!op_legal(head.op) || head.vl == '0) begin
              state <= S_RESP;
              v_r   <= 1'b1;
              err_r <= ~op_legal(head.op);
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          for (int l = 0; l < lanes_p; l++)
            if (lane_act[l] && cur.op != op_redsum)
              resp[lane_idx[l][idx_w-1:0]] <= lane_res[l];
          acc  <= beat_sum;
          base <= next_base[vl_w-1:0];
          if (last_beat) begin
            state <= S_RESP;
            v_r   <= 1'b1;
            if (cur.op == op_redsum) resp[0] <= beat_sum;
          end
        end
        S_RESP: begin
          if (bus.yumi_i) begin
            state <= S_IDLE;
            v_r   <= 1'b0;
            err_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    r_data = '0;
    for (int j = 0; j < vlen_p; j++) r_data[j*vdw_p +: vdw_p] = resp[j];
  end

  assign bus.r_data_o = r_data;
  assign bus.v_o      = v_r;
  assign bus.err_o    = err_r;
endmodule

// File: tb/tb_vector_unit_stream.sv
// tb/tb_vector_unit_stream.sv - directed table-driven bench for vector_unit_stream
module tb_vector_unit_stream;
  localparam int els_p       = 8;
  localparam int vlen_p      = 16;
  localparam int vdw_p       = 8;
  localparam int lanes_p     = 4;
  localparam int cmd_depth_p = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_unit_stream_if #(.els_p(els_p), .vlen_p(vlen_p), .vdw_p(vdw_p)) bus ();

  vector_unit_stream #(
    .els_p       (els_p),
    .vlen_p      (vlen_p),
    .vdw_p       (vdw_p),
    .lanes_p     (lanes_p),
    .cmd_depth_p (cmd_depth_p)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [2:0]   a;
    logic [2:0]   b;
    logic [2:0]   c;
    logic [7:0]   scalar;
    logic [4:0]   vl;
    logic [127:0] wdata;
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t tbl [15];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] ramp(input int start, input int n);
    logic [127:0] d = '0;
    for (int k = 0; k < n; k++) d[k*8 +: 8] = 8'(start + k);
    return d;
  endfunction

  function automatic logic [127:0] fill(input int val, input int n);
    logic [127:0] d = '0;
    for (int k = 0; k < n; k++) d[k*8 +: 8] = 8'(val);
    return d;
  endfunction

  function automatic logic [127:0] mulv(input int s, input int n);
    logic [127:0] d = '0;
    for (int k = 0; k < n; k++) d[k*8 +: 8] = 8'((k + 1) * s);
    return d;
  endfunction

  task automatic set_vec(input int i, input string n, input logic [3:0] op,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic [7:0] s, input logic [4:0] vl, input logic [127:0] wd,
                         input logic [127:0] ed, input logic ee, input int el);
    tbl[i].name = n;  tbl[i].op = op;  tbl[i].a = a;  tbl[i].b = b;  tbl[i].c = c;
    tbl[i].scalar = s;  tbl[i].vl = vl;  tbl[i].wdata = wd;
    tbl[i].exp_data = ed;  tbl[i].exp_err = ee;  tbl[i].exp_lat = el;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [7:0] s, input logic [4:0] vl,
                           input logic [127:0] wd);
    bus.op_i = op;  bus.addrA_i = a;  bus.addrB_i = b;  bus.addrC_i = c;
    bus.scalar_i = s;  bus.vl_i = vl;  bus.w_data_i = wd;
  endtask

  // Issue one command into an idle unit, measure accept-to-v_o latency, then consume it
  task automatic run_vec(input vec_t v);
    int n;
    drive_cmd(v.op, v.a, v.b, v.c, v.scalar, v.vl, v.wdata);
    bus.v_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.ready_o) begin
      total_cnt++;
      $display("FAIL %s_ready: got ready_o=0 for 50 cycles, expected 1", v.name);
    end
    @(posedge clk); #1;
    bus.v_i = 1'b0;
    n = 0;
    while (!bus.v_o && n < 50) begin @(posedge clk); #1; n++; end
    check({v.name, "_lat"}, 128'(n), 128'(v.exp_lat));
    check({v.name, "_data"}, bus.r_data_o, v.exp_data);
    check({v.name, "_err"}, 128'(bus.err_o), 128'(v.exp_err));
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
  endtask

  task automatic get_resp(input string name, input logic [127:0] exp);
    int n = 0;
    while (!bus.v_o && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_valid"}, 128'(bus.v_o), 128'(1));
    check({name, "_data"}, bus.r_data_o, exp);
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
  endtask

  logic [127:0] v1_alias;
  logic [127:0] snap;
  logic [127:0] q_exp [3];
  logic [2:0]   q_a [4];
  vec_t         rd;
  int           accepted;
  bit           was_ready;
  bit           bad;

  initial begin
    bus.v_i = 1'b0;  bus.yumi_i = 1'b0;
    drive_cmd(4'd0, 3'd0, 3'd0, 3'd0, 8'd0, 5'd0, '0);

    v1_alias = ramp(1, 16);
    v1_alias[23:0] = {8'd4, 8'd3, 8'd2};

    set_vec(0,  "wr_v1",      4'b1001, 3'd0, 3'd0, 3'd1, 8'd0,  5'd16, ramp(1, 16),   ramp(1, 16),   1'b0, 5);
    set_vec(1,  "rd_v1",      4'b1000, 3'd1, 3'd0, 3'd0, 8'd0,  5'd16, '0,            ramp(1, 16),   1'b0, 5);
    set_vec(2,  "wr_v2",      4'b1001, 3'd0, 3'd0, 3'd2, 8'd0,  5'd16, fill(200, 16), fill(200, 16), 1'b0, 5);
    set_vec(3,  "add_vl6",    4'b0000, 3'd1, 3'd2, 3'd3, 8'd0,  5'd6,  '0,            ramp(201, 6),  1'b0, 3);
    set_vec(4,  "rd_v3",      4'b1000, 3'd3, 3'd0, 3'd0, 8'd0,  5'd16, '0,            ramp(201, 6),  1'b0, 5);
    set_vec(5,  "mul_scalar", 4'b0110, 3'd1, 3'd0, 3'd4, 8'd20, 5'd16, '0,            mulv(20, 16),  1'b0, 5);
    set_vec(6,  "redsum16",   4'b0011, 3'd1, 3'd0, 3'd0, 8'd0,  5'd16, '0,            128'd136,      1'b0, 5);
    set_vec(7,  "vl0",        4'b0000, 3'd1, 3'd2, 3'd1, 8'd0,  5'd0,  '0,            '0,            1'b0, 1);
    set_vec(8,  "rd_v1_vl0",  4'b1000, 3'd1, 3'd0, 3'd0, 8'd0,  5'd16, '0,            ramp(1, 16),   1'b0, 5);
    set_vec(9,  "illegal",    4'b0111, 3'd1, 3'd2, 3'd1, 8'd0,  5'd16, '0,            '0,            1'b1, 1);
    set_vec(10, "wr_vl20",    4'b1001, 3'd0, 3'd0, 3'd5, 8'd0,  5'd20, ramp(1, 16),   ramp(1, 16),   1'b0, 5);
    set_vec(11, "sub_vl5",    4'b0001, 3'd1, 3'd2, 3'd6, 8'd0,  5'd5,  '0,            ramp(57, 5),   1'b0, 3);
    set_vec(12, "adds_alias", 4'b0100, 3'd1, 3'd0, 3'd1, 8'd1,  5'd3,  '0,            ramp(2, 3),    1'b0, 2);
    set_vec(13, "rd_v1_alias",4'b1000, 3'd1, 3'd0, 3'd0, 8'd0,  5'd16, '0,            v1_alias,      1'b0, 5);
    set_vec(14, "redsum_vl2", 4'b0011, 3'd1, 3'd0, 3'd0, 8'd0,  5'd2,  '0,            128'd5,        1'b0, 2);

    // Reset values while reset is held, then ready after the first edge
    #12;
    check("rst_v_o", 128'(bus.v_o), 128'(0));
    check("rst_err_o", 128'(bus.err_o), 128'(0));
    check("rst_r_data", bus.r_data_o, '0);
    check("rst_ready", 128'(bus.ready_o), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 128'(bus.ready_o), 128'(1));

    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i]);
      if (i == 5) begin
        check("mul_el13", 128'(bus.r_data_o[12*8 +: 8]), 128'(4));
        check("mul_el16", 128'(bus.r_data_o[15*8 +: 8]), 128'(64));
      end
    end

    // Fill the queue with yumi held low
    q_a[0] = 3'd1;  q_a[1] = 3'd2;  q_a[2] = 3'd3;  q_a[3] = 3'd5;
    q_exp[0] = v1_alias;  q_exp[1] = fill(200, 16);  q_exp[2] = ramp(201, 6);
    accepted = 0;
    bad = 1'b0;
    drive_cmd(4'b1000, q_a[0], 3'd0, 3'd0, 8'd0, 5'd16, '0);
    bus.v_i = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      was_ready = bus.ready_o;
      if (accepted == 3 && was_ready) bad = 1'b1;
      @(posedge clk); #1;
      if (was_ready && bus.v_i) begin
        accepted++;
        if (accepted < 4) drive_cmd(4'b1000, q_a[accepted], 3'd0, 3'd0, 8'd0, 5'd16, '0);
        else bus.v_i = 1'b0;
      end
    end
    bus.v_i = 1'b0;
    check("full_accepts", 128'(accepted), 128'(3));
    check("full_ready_low", 128'(bus.ready_o), 128'(0));
    check("full_ready_held", 128'(bad), 128'(0));
    check("full_v_o", 128'(bus.v_o), 128'(1));
    snap = bus.r_data_o;
    bad = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (bus.r_data_o !== snap || !bus.v_o) bad = 1'b1;
    end
    check("resp_stable", 128'(bad), 128'(0));
    check("resp_stable_val", snap, q_exp[0]);
    for (int k = 0; k < 3; k++) get_resp($sformatf("drain%0d", k), q_exp[k]);
    check("ready_after_drain", 128'(bus.ready_o), 128'(1));

    // Reset in the middle of a 4-beat add into v1
    drive_cmd(4'b0000, 3'd1, 3'd2, 3'd1, 8'd0, 5'd16, '0);
    bus.v_i = 1'b1;
    @(posedge clk); #1;
    bus.v_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_v_o", 128'(bus.v_o), 128'(0));
    check("midrst_err", 128'(bus.err_o), 128'(0));
    check("midrst_r_data", bus.r_data_o, '0);
    check("midrst_ready", 128'(bus.ready_o), 128'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (bus.v_o) bad = 1'b1;
    end
    check("midrst_no_resp", 128'(bad), 128'(0));
    rd = tbl[1];
    rd.name = "rd_v1_zero";  rd.exp_data = '0;
    run_vec(rd);
    rd.name = "rd_v2_zero";  rd.a = 3'd2;
    run_vec(rd);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
